qpu_exu_lsu_pipe: RTL and testbench
===================================

# qpu_exu_lsu_pipe

Parametrised load/store unit for the QPU execute stage. It succeeds the single-word, fire-and-forget LSU with four additions: byte, half and word accesses with byte masks; misalignment detection; an ICB response channel; and an in-order queue of outstanding loads that returns sign- or zero-extended data to the register-file write-back port. It sits between the ALU dispatch and the LSU-ctrl ICB bus. Stores commit on command handshake; loads commit on command handshake and write back when their response arrives.

## Interface
- `XLEN`, 32: data width, a power of two ≥ 32.
- `ADDR_SIZE`, 32: bus address width, ≤ `XLEN`.
- `OUTS_DEPTH`, 2: maximum number of outstanding loads, ≥ 1.
- `RDIDX_W`, 5: width of the destination register index.
- `clk` (in, 1): clock; the block has one clock.
- `rst_n` (in, 1): reset, asynchronous and active-low.
- `lsu_i_valid` (in, 1) / `lsu_i_ready` (out, 1): issue handshake.
- `lsu_i_rs1`, `lsu_i_rs2`, `lsu_i_imm` (in, `XLEN`): base, store data and offset.
- `lsu_i_info` (in, `QPU_DECINFO_LSU_WIDTH`): fields LOAD, STORE, SIZE[1:0] (0 = byte, 1 = half, 2 = word), USIGN.
- `lsu_i_rdidx` (in, `RDIDX_W`): load destination.
- `lsu_o_valid` (out, 1) / `lsu_o_ready` (in, 1): commit handshake.
- `lsu_o_misalgn` (out, 1): commit carries a misaligned exception.
- `lsu_o_badaddr` (out, `ADDR_SIZE`): faulting address.
- `lsu_icb_cmd_valid` (out, 1) / `lsu_icb_cmd_ready` (in, 1): ICB command handshake.
- `lsu_icb_cmd_addr` (out, `ADDR_SIZE`), `lsu_icb_cmd_read` (out, 1), `lsu_icb_cmd_wdata` (out, `XLEN`), `lsu_icb_cmd_wmask` (out, `XLEN/8`): command payload.
- `lsu_icb_rsp_valid` (in, 1) / `lsu_icb_rsp_ready` (out, 1): ICB response handshake.
- `lsu_icb_rsp_rdata` (in, `XLEN`), `lsu_icb_rsp_err` (in, 1): response payload.
- `lsu_wbck_valid` (out, 1) / `lsu_wbck_ready` (in, 1): load write-back handshake.
- `lsu_wbck_rdidx` (out, `RDIDX_W`), `lsu_wbck_wdata` (out, `XLEN`), `lsu_wbck_err` (out, 1): write-back payload.
- `lsu_outs_cnt` (out, `clog2(OUTS_DEPTH+1)`): number of outstanding loads.
- `lsu_idle` (out, 1): high when `lsu_outs_cnt` is 0.

## Operation
- Address: `addr = rs1 + imm`, truncated to `ADDR_SIZE`. The adder is internal; the block has no ALU sharing.
- `ldst = LOAD | STORE`. `misalgn = ldst & ((SIZE==1 & addr[0]) | (SIZE==2 & addr[1:0]!=0))`.
- `full = outs_cnt==OUTS_DEPTH`. `room = STORE | !full`.
- Misaligned access: no ICB command is issued. `lsu_o_valid = lsu_i_valid`, `lsu_i_ready = lsu_o_ready`, `lsu_o_misalgn = 1`, `badaddr = addr`.
- Aligned access:
  - `cmd_valid = i_valid & o_ready & room`.
  - `o_valid = i_valid & cmd_ready & room`.
  - `i_ready = cmd_ready & o_ready & room`.
- `cmd_read = LOAD`. `cmd_addr = addr` exactly as computed; it is not word-aligned.
- Store wdata replicates `rs2` by size: byte is `{XLEN/8{rs2[7:0]}}`, half is `{XLEN/16{rs2[15:0]}}`, word is `rs2`.
- Store wmask by size: byte is `1 << addr[lsb]`, half is `3 << addr[lsb]` (lsb is the byte-lane index bits), word is the lanes selected by `addr` within `XLEN`. When `XLEN==32`, word is all ones.
- Load wmask is 0.
- Each accepted load command pushes `{rdidx, SIZE, USIGN, addr lane bits}` into the outstanding FIFO.
- Response path:
  - `rsp_ready = !empty & wbck_ready`.
  - `wbck_valid = rsp_valid & !empty`.
  - A handshake pops the FIFO.
  - `wbck_wdata` is `rdata` shifted right by the lane offset times 8, then sign-extended (USIGN=0) or zero-extended (USIGN=1) from the access size.
  - `wbck_err = rsp_err`. Data is still formatted when `err` is set.
- A response arriving while the FIFO is empty is not acknowledged (`rsp_ready = 0`). It is a protocol violation and must be flagged by a bench assertion.
- Push and pop in the same cycle leave the count unchanged. Push is gated by `full` as sampled before any pop in that cycle; a same-cycle pop does not admit a push while full.
- Instructions with `ldst = 0` are never valid here. If one arrives, the block asserts `o_valid` and issues no command.

## Timing
- Issue to ICB command and commit takes 0 cycles: the path is combinational.
- Response to write-back takes 0 cycles: the path is combinational.
- FIFO and count update on the rising edge of `clk`.
- Responses are strictly in order. The FIFO holds one entry per outstanding load.
- Reset (`rst_n` low, asynchronous) clears the FIFO pointers and `outs_cnt` to 0. Reset values of outputs:
  - `lsu_idle` = 1.
  - `lsu_wbck_valid` = 0.
  - `lsu_icb_rsp_ready` = 0.
  - All other outputs follow their combinational inputs.
- Reset mid-operation discards all outstanding entries. The downstream ICB is reset together with this block.
- Maximum throughput is one load or store per cycle, provided `OUTS_DEPTH` covers the bus latency.

## Structure
- `QPU_defines.v` gains `QPU_DECINFO_LSU_SIZE`, `QPU_DECINFO_LSU_USIGN` and the size encodings `QPU_LSU_SIZE_B/H/W`.
- One sub-module, `qpu_gnrl_fifo`: a parameterised synchronous FIFO (`DP`, `DW`) with full and empty flags. It holds the outstanding-load entries.

## Test plan
- Store word, `rs1=0x100`, `imm=4`, `rs2=0xDEADBEEF`, `cmd_ready=1` → the same cycle shows `cmd_addr=0x104`, `wmask=4'b1111`, `wdata=0xDEADBEEF`, `o_valid=1`.
- Store byte to `0x103` with `rs2=0xAB` → `wdata=0xABABABAB`, `wmask=4'b1000`.
- Load half to `0x102` with SIZE=1, USIGN=0, `rdidx=7`; response `rdata=0x80010000` → `wbck_rdidx=7`, `wdata=0xFFFF8001`. With USIGN=1 → `0x00008001`.
- Load word to `0x101` → `o_misalgn=1`, `badaddr=0x101`, `cmd_valid` never asserted, `outs_cnt` stays 0.
- With `OUTS_DEPTH=2`, issue three loads back-to-back with no response → the third sees `i_ready=0`. After one response handshake, it is accepted the next cycle; `outs_cnt` goes 1, 2, 2, and returns to 0 once all responses are drained.
- Assert `rst_n` low with 2 loads outstanding → `outs_cnt=0` and `lsu_idle=1` immediately, `wbck_valid=0`.

Source files
------------

// File: rtl/qpu_exu_lsu_pipe_pkg.sv
// Shared definitions for the QPU execute-stage load/store unit.
//   - LSU decode-info field positions and total width
//   - access size encodings (byte / half / word)
//   - lsu_info_t: packed view of lsu_i_info (LOAD at bit 0)
package qpu_exu_lsu_pipe_pkg;

    localparam int QPU_DECINFO_LSU_LOAD  = 0;
    localparam int QPU_DECINFO_LSU_STORE = 1;
    localparam int QPU_DECINFO_LSU_SIZE  = 2;   // two bits: [3:2]
    localparam int QPU_DECINFO_LSU_USIGN = 4;
    localparam int QPU_DECINFO_LSU_WIDTH = 5;

    localparam logic [1:0] QPU_LSU_SIZE_B = 2'd0;
    localparam logic [1:0] QPU_LSU_SIZE_H = 2'd1;
    localparam logic [1:0] QPU_LSU_SIZE_W = 2'd2;

    // Field order matches the bit positions above (MSB first).
    typedef struct packed {
        logic       usign;
        logic [1:0] size;
        logic       store;
        logic       load;
    } lsu_info_t;

endpackage

// File: rtl/qpu_gnrl_fifo.sv
// Parameterised synchronous FIFO holding the outstanding-load entries.
//   clk, rst_n        : clock, async active-low reset (clears pointers/count)
//   push_i, wdat_i    : write request and data; ignored while full
//   pop_i, rdat_o     : read request and head data; ignored while empty
//   full_o, empty_o   : status flags
//   cnt_o             : number of stored entries
module qpu_gnrl_fifo #(
    parameter int DP = 2,
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            wdat_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            rdat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DP+1)-1:0]  cnt_o
);
    localparam int PTR_W = (DP > 1) ? $clog2(DP) : 1;
    localparam int CNT_W = $clog2(DP+1);

    logic [DW-1:0]    mem_q [DP];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DP-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (cnt_q == CNT_W'(DP));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;
    assign rdat_o  = mem_q[rptr_q];

    // Full is the pre-pop flag, so a pop never makes room for a same-cycle push.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
        if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdat_i;
    end

endmodule

// File: rtl/qpu_exu_lsu_pipe.sv
// QPU execute-stage load/store unit.
// Issues byte/half/word ICB commands from the ALU dispatch, flags misaligned
// accesses, tracks outstanding loads in order and returns extended load data
// to the register-file write-back port.
//   lsu_i_*        : issue handshake and operands (rs1 + imm = address)
//   lsu_o_*        : commit handshake with misaligned exception / bad address
//   lsu_icb_cmd_*  : ICB command channel (addr, read, wdata, wmask)
//   lsu_icb_rsp_*  : ICB response channel (rdata, err)
//   lsu_wbck_*     : load write-back (rdidx, wdata, err)
//   lsu_outs_cnt   : outstanding loads; lsu_idle when zero
module qpu_exu_lsu_pipe
    import qpu_exu_lsu_pipe_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int OUTS_DEPTH = 2,
    parameter int RDIDX_W    = 5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              lsu_i_valid,
    output logic                              lsu_i_ready,
    input  logic [XLEN-1:0]                   lsu_i_rs1,
    input  logic [XLEN-1:0]                   lsu_i_rs2,
    input  logic [XLEN-1:0]                   lsu_i_imm,
    input  logic [QPU_DECINFO_LSU_WIDTH-1:0]  lsu_i_info,
    input  logic [RDIDX_W-1:0]                lsu_i_rdidx,
    output logic                              lsu_o_valid,
    input  logic                              lsu_o_ready,
    output logic                              lsu_o_misalgn,
    output logic [ADDR_SIZE-1:0]              lsu_o_badaddr,
    output logic                              lsu_icb_cmd_valid,
    input  logic                              lsu_icb_cmd_ready,
    output logic [ADDR_SIZE-1:0]              lsu_icb_cmd_addr,
    output logic                              lsu_icb_cmd_read,
    output logic [XLEN-1:0]                   lsu_icb_cmd_wdata,
    output logic [XLEN/8-1:0]                 lsu_icb_cmd_wmask,
    input  logic                              lsu_icb_rsp_valid,
    output logic                              lsu_icb_rsp_ready,
    input  logic [XLEN-1:0]                   lsu_icb_rsp_rdata,
    input  logic                              lsu_icb_rsp_err,
    output logic                              lsu_wbck_valid,
    input  logic                              lsu_wbck_ready,
    output logic [RDIDX_W-1:0]                lsu_wbck_rdidx,
    output logic [XLEN-1:0]                   lsu_wbck_wdata,
    output logic                              lsu_wbck_err,
    output logic [$clog2(OUTS_DEPTH+1)-1:0]   lsu_outs_cnt,
    output logic                              lsu_idle
);
    localparam int MASK_W = XLEN/8;
    localparam int LANE_W = $clog2(MASK_W);
    localparam int CNT_W  = $clog2(OUTS_DEPTH+1);
    localparam int ENT_W  = RDIDX_W + 3 + LANE_W;

    lsu_info_t            info;
    logic [XLEN-1:0]      addr_full;
    logic [ADDR_SIZE-1:0] addr;
    logic [LANE_W-1:0]    lane;
    logic                 ldst, misalgn, aligned, room;
    logic                 fifo_full, fifo_empty, push, pop;
    logic [ENT_W-1:0]     ent_in, ent_hd;
    logic [RDIDX_W-1:0]   hd_rdidx;
    logic [1:0]           hd_size;
    logic                 hd_usign;
    logic [LANE_W-1:0]    hd_lane;
    logic [XLEN-1:0]      rsp_sh;
    logic [CNT_W-1:0]     cnt;

    assign info      = lsu_i_info;
    assign addr_full = lsu_i_rs1 + lsu_i_imm;
    assign addr      = addr_full[ADDR_SIZE-1:0];
    assign lane      = addr[LANE_W-1:0];

    assign ldst    = info.load | info.store;
    assign misalgn = ldst & (((info.size == QPU_LSU_SIZE_H) & addr[0]) |
                             ((info.size == QPU_LSU_SIZE_W) & (addr[1:0] != 2'b00)));
    assign aligned = ldst & ~misalgn;
    // Stores are not tracked, so only loads wait for a free FIFO slot.
    assign room    = info.store | ~fifo_full;

    // Misaligned and non-memory instructions bypass the bus and commit directly.
    always_comb begin
        lsu_icb_cmd_valid = 1'b0;
        lsu_o_valid       = lsu_i_valid;
        lsu_i_ready       = lsu_o_ready;
        if (aligned) begin
            lsu_icb_cmd_valid = lsu_i_valid & lsu_o_ready & room;
            lsu_o_valid       = lsu_i_valid & lsu_icb_cmd_ready & room;
            lsu_i_ready       = lsu_icb_cmd_ready & lsu_o_ready & room;
        end
    end

    assign lsu_o_misalgn    = misalgn;
    assign lsu_o_badaddr    = addr;
    assign lsu_icb_cmd_addr = addr;
    assign lsu_icb_cmd_read = info.load;

    always_comb begin
        case (info.size)
            QPU_LSU_SIZE_B: lsu_icb_cmd_wdata = {MASK_W{lsu_i_rs2[7:0]}};
            QPU_LSU_SIZE_H: lsu_icb_cmd_wdata = {(XLEN/16){lsu_i_rs2[15:0]}};
            default:        lsu_icb_cmd_wdata = lsu_i_rs2;
        endcase
    end

    // Word lanes are the 4-byte group addressed within XLEN (all lanes at XLEN=32).
    always_comb begin
        lsu_icb_cmd_wmask = '0;
        if (info.store && !info.load) begin
            case (info.size)
                QPU_LSU_SIZE_B: lsu_icb_cmd_wmask = MASK_W'(1) << lane;
                QPU_LSU_SIZE_H: lsu_icb_cmd_wmask = MASK_W'(3) << lane;
                default:        lsu_icb_cmd_wmask = MASK_W'(4'hF) << (lane & ~LANE_W'(3));
            endcase
        end
    end

    assign push   = lsu_icb_cmd_valid & lsu_icb_cmd_ready & info.load;
    assign ent_in = {lsu_i_rdidx, info.size, info.usign, lane};

    qpu_gnrl_fifo #(
        .DP (OUTS_DEPTH),
        .DW (ENT_W)
    ) u_outs_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdat_i  (ent_in),
        .pop_i   (pop),
        .rdat_o  (ent_hd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .cnt_o   (cnt)
    );

    assign {hd_rdidx, hd_size, hd_usign, hd_lane} = ent_hd;

    // A response with nothing outstanding is never acknowledged.
    assign lsu_icb_rsp_ready = ~fifo_empty & lsu_wbck_ready;
    assign lsu_wbck_valid    = lsu_icb_rsp_valid & ~fifo_empty;
    assign pop               = lsu_icb_rsp_valid & lsu_icb_rsp_ready;

    assign rsp_sh = lsu_icb_rsp_rdata >> {hd_lane, 3'b000};

    always_comb begin
        case (hd_size)
            QPU_LSU_SIZE_B: lsu_wbck_wdata = hd_usign ? XLEN'(rsp_sh[7:0])
                                                      : {{(XLEN-8){rsp_sh[7]}}, rsp_sh[7:0]};
            QPU_LSU_SIZE_H: lsu_wbck_wdata = hd_usign ? XLEN'(rsp_sh[15:0])
                                                      : {{(XLEN-16){rsp_sh[15]}}, rsp_sh[15:0]};
            default:        lsu_wbck_wdata = rsp_sh;
        endcase
    end

    assign lsu_wbck_rdidx = hd_rdidx;
    assign lsu_wbck_err   = lsu_icb_rsp_err;
    assign lsu_outs_cnt   = cnt;
    assign lsu_idle       = (cnt == '0);

endmodule

// File: tb/tb_qpu_exu_lsu_pipe.sv
module tb_qpu_exu_lsu_pipe;
    import qpu_exu_lsu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_i_valid, lsu_i_ready;
    logic [31:0] lsu_i_rs1, lsu_i_rs2, lsu_i_imm;
    logic [QPU_DECINFO_LSU_WIDTH-1:0] lsu_i_info;
    logic [4:0]  lsu_i_rdidx;
    logic        lsu_o_valid, lsu_o_ready, lsu_o_misalgn;
    logic [31:0] lsu_o_badaddr;
    logic        lsu_icb_cmd_valid, lsu_icb_cmd_ready, lsu_icb_cmd_read;
    logic [31:0] lsu_icb_cmd_addr, lsu_icb_cmd_wdata;
    logic [3:0]  lsu_icb_cmd_wmask;
    logic        lsu_icb_rsp_valid, lsu_icb_rsp_ready, lsu_icb_rsp_err;
    logic [31:0] lsu_icb_rsp_rdata;
    logic        lsu_wbck_valid, lsu_wbck_ready, lsu_wbck_err;
    logic [4:0]  lsu_wbck_rdidx;
    logic [31:0] lsu_wbck_wdata;
    logic [1:0]  lsu_outs_cnt;
    logic        lsu_idle;

    int checks = 0;
    int errors = 0;

    // info encodings: {usign, size[1:0], store, load}
    localparam logic [4:0] I_SB = 5'h02, I_SH = 5'h06, I_SW = 5'h0A;
    localparam logic [4:0] I_LB = 5'h01, I_LH = 5'h05, I_LW = 5'h09, I_LHU = 5'h15;

    qpu_exu_lsu_pipe #(.XLEN(32), .ADDR_SIZE(32), .OUTS_DEPTH(2), .RDIDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_i_valid(lsu_i_valid), .lsu_i_ready(lsu_i_ready),
        .lsu_i_rs1(lsu_i_rs1), .lsu_i_rs2(lsu_i_rs2), .lsu_i_imm(lsu_i_imm),
        .lsu_i_info(lsu_i_info), .lsu_i_rdidx(lsu_i_rdidx),
        .lsu_o_valid(lsu_o_valid), .lsu_o_ready(lsu_o_ready),
        .lsu_o_misalgn(lsu_o_misalgn), .lsu_o_badaddr(lsu_o_badaddr),
        .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
        .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
        .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
        .lsu_icb_rsp_valid(lsu_icb_rsp_valid), .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
        .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata), .lsu_icb_rsp_err(lsu_icb_rsp_err),
        .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
        .lsu_wbck_rdidx(lsu_wbck_rdidx), .lsu_wbck_wdata(lsu_wbck_wdata),
        .lsu_wbck_err(lsu_wbck_err),
        .lsu_outs_cnt(lsu_outs_cnt), .lsu_idle(lsu_idle)
    );

    always #5 clk = ~clk;

    // A response with no outstanding load is a bus protocol violation.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(lsu_icb_rsp_valid && lsu_outs_cnt == 2'd0))
            else begin
                errors++;
                $error("FAIL protocol: response while no load outstanding");
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] rs1, imm, rs2;
        logic [4:0]  info;
        logic        cr, ordy;
        logic        e_cv, e_ov, e_ir, e_mis, e_rd;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_wm;
        logic        wm_chk, wd_chk;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string nm, logic [31:0] rs1, logic [31:0] imm, logic [31:0] rs2,
                                logic [4:0] info, logic cr, logic ordy,
                                logic cv, logic ov, logic ir, logic mis, logic rd,
                                logic [31:0] addr, logic [31:0] wd, logic [3:0] wm,
                                logic wm_chk, logic wd_chk);
        vec_t v;
        v.name = nm; v.rs1 = rs1; v.imm = imm; v.rs2 = rs2; v.info = info;
        v.cr = cr; v.ordy = ordy; v.e_cv = cv; v.e_ov = ov; v.e_ir = ir;
        v.e_mis = mis; v.e_rd = rd; v.e_addr = addr; v.e_wd = wd; v.e_wm = wm;
        v.wm_chk = wm_chk; v.wd_chk = wd_chk;
        return v;
    endfunction

    task automatic idle_in();
        lsu_i_valid = 0; lsu_i_rs1 = 0; lsu_i_rs2 = 0; lsu_i_imm = 0;
        lsu_i_info = 0; lsu_i_rdidx = 0; lsu_o_ready = 1; lsu_icb_cmd_ready = 1;
        lsu_icb_rsp_valid = 0; lsu_icb_rsp_rdata = 0; lsu_icb_rsp_err = 0;
        lsu_wbck_ready = 1;
    endtask

    task automatic issue(input logic [4:0] info, input logic [31:0] a, input logic [4:0] rd);
        lsu_i_valid = 1; lsu_i_info = info; lsu_i_rs1 = a; lsu_i_imm = 0; lsu_i_rdidx = rd;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d, input logic e);
        lsu_icb_rsp_valid = v; lsu_icb_rsp_rdata = d; lsu_icb_rsp_err = e;
    endtask

    initial begin
        //            name     rs1           imm         rs2           info  cr ordy cv ov ir mis rd addr          wdata         wm  wmc wdc
        vecs.push_back(mk("sw",     32'h100,      32'h4, 32'hDEADBEEF, I_SW, 1, 1, 1, 1, 1, 0, 0, 32'h104,      32'hDEADBEEF, 4'hF, 1, 1));
        vecs.push_back(mk("sb3",    32'h100,      32'h3, 32'h000000AB, I_SB, 1, 1, 1, 1, 1, 0, 0, 32'h103,      32'hABABABAB, 4'h8, 1, 1));
        vecs.push_back(mk("sb1",    32'h100,      32'h1, 32'h1234565A, I_SB, 1, 1, 1, 1, 1, 0, 0, 32'h101,      32'h5A5A5A5A, 4'h2, 1, 1));
        vecs.push_back(mk("sh2",    32'h200,      32'h2, 32'h12345678, I_SH, 1, 1, 1, 1, 1, 0, 0, 32'h202,      32'h56785678, 4'hC, 1, 1));
        vecs.push_back(mk("lw_mis", 32'h100,      32'h1, 32'h0,        I_LW, 1, 1, 0, 1, 1, 1, 1, 32'h101,      32'h0,        4'h0, 1, 0));
        vecs.push_back(mk("sw_crl", 32'h100,      32'h0, 32'h1,        I_SW, 0, 1, 1, 0, 0, 0, 0, 32'h100,      32'h1,        4'hF, 1, 1));
        vecs.push_back(mk("sw_orl", 32'h100,      32'h0, 32'h1,        I_SW, 1, 0, 0, 1, 0, 0, 0, 32'h100,      32'h1,        4'hF, 1, 1));
        vecs.push_back(mk("lh_mis", 32'h100,      32'h3, 32'h0,        I_LH, 1, 1, 0, 1, 1, 1, 1, 32'h103,      32'h0,        4'h0, 1, 0));
        vecs.push_back(mk("lb3",    32'h100,      32'h3, 32'h0,        I_LB, 1, 1, 1, 1, 1, 0, 1, 32'h103,      32'h0,        4'h0, 1, 0));
        vecs.push_back(mk("sw_mis", 32'h100,      32'h2, 32'h0,        I_SW, 1, 0, 0, 1, 0, 1, 0, 32'h102,      32'h0,        4'h0, 0, 0));
        vecs.push_back(mk("nop",    32'h100,      32'h0, 32'h0,        5'h0, 1, 1, 0, 1, 1, 0, 0, 32'h100,      32'h0,        4'h0, 0, 0));
        vecs.push_back(mk("wrap",   32'hFFFFFFFC, 32'h8, 32'hCAFEF00D, I_SW, 1, 1, 1, 1, 1, 0, 0, 32'h4,        32'hCAFEF00D, 4'hF, 1, 1));

        idle_in();
        rst_n = 0;
        #1;
        chk("rst_idle", lsu_idle, 1);
        chk("rst_cnt", lsu_outs_cnt, 0);
        chk("rst_wbck_valid", lsu_wbck_valid, 0);
        chk("rst_rsp_ready", lsu_icb_rsp_ready, 0);
        @(negedge clk); rst_n = 1;

        // Combinational issue path: inputs are dropped before the next rising edge.
        foreach (vecs[i]) begin
            @(negedge clk);
            lsu_i_valid = 1; lsu_i_rs1 = vecs[i].rs1; lsu_i_imm = vecs[i].imm;
            lsu_i_rs2 = vecs[i].rs2; lsu_i_info = vecs[i].info;
            lsu_icb_cmd_ready = vecs[i].cr; lsu_o_ready = vecs[i].ordy;
            #1;
            chk({vecs[i].name, " cmd_valid"}, lsu_icb_cmd_valid, vecs[i].e_cv);
            chk({vecs[i].name, " o_valid"}, lsu_o_valid, vecs[i].e_ov);
            chk({vecs[i].name, " i_ready"}, lsu_i_ready, vecs[i].e_ir);
            chk({vecs[i].name, " misalgn"}, lsu_o_misalgn, vecs[i].e_mis);
            chk({vecs[i].name, " badaddr"}, lsu_o_badaddr, vecs[i].e_addr);
            if (vecs[i].e_cv) begin
                chk({vecs[i].name, " cmd_addr"}, lsu_icb_cmd_addr, vecs[i].e_addr);
                chk({vecs[i].name, " cmd_read"}, lsu_icb_cmd_read, vecs[i].e_rd);
            end
            if (vecs[i].wm_chk) chk({vecs[i].name, " wmask"}, lsu_icb_cmd_wmask, vecs[i].e_wm);
            if (vecs[i].wd_chk) chk({vecs[i].name, " wdata"}, lsu_icb_cmd_wdata, vecs[i].e_wd);
            #1;
            idle_in();
        end
        @(negedge clk);
        chk("tbl_cnt", lsu_outs_cnt, 0);

        // Load formatting, including write-back back-pressure and error pass-through.
        issue(I_LH, 32'h102, 5'd7);
        @(negedge clk); idle_in();
        chk("lh_cnt", lsu_outs_cnt, 1);
        rsp(1, 32'h80010000, 0); lsu_wbck_ready = 0; #1;
        chk("lh_hold_wv", lsu_wbck_valid, 1);
        chk("lh_hold_rr", lsu_icb_rsp_ready, 0);
        @(negedge clk);
        chk("lh_hold_cnt", lsu_outs_cnt, 1);
        lsu_wbck_ready = 1; #1;
        chk("lh_rr", lsu_icb_rsp_ready, 1);
        chk("lh_rdidx", lsu_wbck_rdidx, 7);
        chk("lh_wdata", lsu_wbck_wdata, 32'hFFFF8001);
        chk("lh_err", lsu_wbck_err, 0);
        @(negedge clk); rsp(0, 0, 0);
        chk("lh_cnt0", lsu_outs_cnt, 0);
        issue(I_LHU, 32'h102, 5'd9);
        @(negedge clk); idle_in();
        rsp(1, 32'h80010000, 1); #1;
        chk("lhu_wdata", lsu_wbck_wdata, 32'h00008001);
        chk("lhu_err", lsu_wbck_err, 1);
        chk("lhu_rdidx", lsu_wbck_rdidx, 9);
        @(negedge clk); rsp(0, 0, 0);
        issue(I_LB, 32'h103, 5'd3);
        @(negedge clk); idle_in();
        rsp(1, 32'h80123456, 0); #1;
        chk("lb_wdata", lsu_wbck_wdata, 32'hFFFFFF80);
        @(negedge clk); rsp(0, 0, 0);
        chk("lb_cnt0", lsu_outs_cnt, 0);

        // Outstanding limit: third load stalls until a slot is freed.
        issue(I_LW, 32'h200, 5'd1); #1;
        chk("o1_ir", lsu_i_ready, 1);
        @(negedge clk);
        chk("o1_cnt", lsu_outs_cnt, 1);
        issue(I_LW, 32'h204, 5'd2); #1;
        chk("o2_ir", lsu_i_ready, 1);
        @(negedge clk);
        chk("o2_cnt", lsu_outs_cnt, 2);
        issue(I_LW, 32'h208, 5'd3); #1;
        chk("o3_ir", lsu_i_ready, 0);
        chk("o3_cv", lsu_icb_cmd_valid, 0);
        @(negedge clk);
        chk("o3_cnt", lsu_outs_cnt, 2);
        rsp(1, 32'h11111111, 0); #1;
        chk("o4_rdidx", lsu_wbck_rdidx, 1);
        chk("o4_ir_full", lsu_i_ready, 0);
        @(negedge clk); rsp(0, 0, 0); #1;
        chk("o5_cnt", lsu_outs_cnt, 1);
        chk("o5_ir", lsu_i_ready, 1);
        @(negedge clk); idle_in();
        chk("o6_cnt", lsu_outs_cnt, 2);
        rsp(1, 32'h22222222, 0); #1;
        chk("o6_rdidx", lsu_wbck_rdidx, 2);
        chk("o6_wdata", lsu_wbck_wdata, 32'h22222222);
        @(negedge clk);
        chk("o7_cnt", lsu_outs_cnt, 1);
        issue(I_LW, 32'h20C, 5'd4); rsp(1, 32'h33333333, 0); #1;
        chk("o7_rdidx", lsu_wbck_rdidx, 3);
        chk("o7_ir", lsu_i_ready, 1);
        @(negedge clk); lsu_i_valid = 0;
        chk("o8_cnt_pushpop", lsu_outs_cnt, 1);
        rsp(1, 32'h44444444, 0); #1;
        chk("o8_rdidx", lsu_wbck_rdidx, 4);
        @(negedge clk); rsp(0, 0, 0);
        chk("o9_cnt", lsu_outs_cnt, 0);
        chk("o9_idle", lsu_idle, 1);

        // Asynchronous reset with two loads outstanding.
        issue(I_LW, 32'h300, 5'd5);
        @(negedge clk); issue(I_LW, 32'h304, 5'd6);
        @(negedge clk); idle_in();
        chk("r_cnt2", lsu_outs_cnt, 2);
        rsp(1, 32'h55555555, 0);
        #1 rst_n = 0;
        #1;
        chk("r_cnt", lsu_outs_cnt, 0);
        chk("r_idle", lsu_idle, 1);
        chk("r_wv", lsu_wbck_valid, 0);
        chk("r_rr", lsu_icb_rsp_ready, 0);
        rsp(0, 0, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        chk("r_after_cnt", lsu_outs_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
